// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM encoding, default widths,
// and the EX/MEM and MEM/WB pipeline bundles.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] alu_out;
    logic [DATA_W_DEF-1:0] wdata;
    logic [REG_W_DEF-1:0]  reg_dest;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_W_DEF-1:0]  reg_dest;
    logic [DATA_W_DEF-1:0] data;
  } mem_wb_t;

  // Register 0 is hardwired, so it is never a write or forward target.
  function automatic logic writes_reg(
    input logic                 valid,
    input logic                 reg_write,
    input logic [REG_W_DEF-1:0] dest
  );
    return valid & reg_write & (dest != '0);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: IDLE/ACCESS state, wait counter,
// request, stall and timeout generation.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   ack,
  output state_t state,
  output logic   req,
  output logic   stall,
  output logic   timeout_hit
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  assign req         = (state == ST_ACCESS);
  assign timeout_hit = req & ~ack & (count == CW'(TIMEOUT - 1));
  assign stall       = req & ~ack & ~timeout_hit;

  // A non-stall edge is exactly when EX/MEM reloads, so the next
  // state follows whatever instruction is being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (!stall) begin
      state <= start ? ST_ACCESS : ST_IDLE;
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory handshake,
// MEM/WB register and forwarding taps.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_reg_dest,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] pre_data,
  output logic [REG_W-1:0]  pre_reg_dest,
  output logic              pre_reg_write,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_reg_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  ex_mem_t           exm;
  mem_wb_t           mwb;
  state_t            state;
  logic              req;
  logic              timeout_hit;
  logic              start;
  logic              ack_ok;
  logic [DATA_W-1:0] wb_mux;

  assign start  = ex_valid & (ex_mem_read | ex_mem_write);
  assign ack_ok = dmem_ack & req;

  mem_access_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ack        (dmem_ack),
    .state      (state),
    .req        (req),
    .stall      (stall),
    .timeout_hit(timeout_hit)
  );

  // An aborted load has no data to return, so it writes back zero.
  always_comb begin
    wb_mux = exm.alu_out;
    if (exm.mem_to_reg) wb_mux = ack_ok ? dmem_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm     <= '0;
      mwb     <= '0;
      mem_err <= 1'b0;
    end else begin
      if (timeout_hit) mem_err <= 1'b1;
      if (!stall) begin
        if (ex_valid) begin
          exm <= '{valid:      1'b1,
                   alu_out:    ex_alu_out,
                   wdata:      ex_wdata,
                   reg_dest:   ex_reg_dest,
                   mem_read:   ex_mem_read,
                   mem_write:  ex_mem_write,
                   reg_write:  ex_reg_write,
                   mem_to_reg: ex_mem_to_reg};
        end else begin
          exm <= '0;
        end
        mwb <= '{valid:     exm.valid,
                 reg_write: writes_reg(exm.valid, exm.reg_write,
                                       exm.reg_dest),
                 reg_dest:  exm.reg_dest,
                 data:      wb_mux};
      end
    end
  end

  // A store wins when read and write are both set.
  assign dmem_req      = req;
  assign dmem_we       = req & exm.mem_write;
  assign dmem_addr     = exm.alu_out;
  assign dmem_wdata    = exm.wdata;

  assign pre_data      = exm.alu_out;
  assign pre_reg_dest  = exm.reg_dest;
  assign pre_reg_write = writes_reg(exm.valid, exm.reg_write, exm.reg_dest);

  assign wb_valid      = mwb.valid;
  assign wb_reg_write  = mwb.reg_write;
  assign wb_reg_dest   = mwb.reg_dest;
  assign wb_data       = mwb.data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected writebacks
// plus a latency-programmable data-memory model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_out = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_reg_dest = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] pre_data;
  logic [4:0]  pre_reg_dest;
  logic        pre_reg_write;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_dest;
  logic [31:0] wb_data;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_stage #(
    .DATA_W (32),
    .REG_W  (5),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_alu_out   (ex_alu_out),
    .ex_wdata     (ex_wdata),
    .ex_reg_dest  (ex_reg_dest),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .pre_data     (pre_data),
    .pre_reg_dest (pre_reg_dest),
    .pre_reg_write(pre_reg_write),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_reg_dest  (wb_reg_dest),
    .wb_data      (wb_data),
    .mem_err      (mem_err)
  );

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        m2r;
    int          lat;
    logic [31:0] rdata;
  } ins_t;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  ins_t exm;
  logic exm_full = 1'b0;
  int   acc = 0;
  int   req_cnt = 0;
  int   stall_cnt = 0;
  int   wr_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic ins_t mk(
    input logic v, input logic [31:0] alu, input logic [31:0] wd,
    input logic [4:0] d, input logic rd, input logic wr,
    input logic rw, input logic m2r, input int lat,
    input logic [31:0] rdat
  );
    ins_t i;
    i.valid = v; i.alu = alu; i.wdata = wd; i.dest = d;
    i.rd = rd; i.wr = wr; i.rw = rw; i.m2r = m2r;
    i.lat = lat; i.rdata = rdat;
    return i;
  endfunction

  function automatic ins_t bubble();
    return mk(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
  endfunction

  // Reference behaviour: ack arrives in cycle lat unless the timeout
  // fires first; unacked loads return zero.
  function automatic exp_t expect_of(input ins_t i);
    exp_t e;
    logic acked;
    acked   = (i.rd || i.wr) && i.lat != 0 && i.lat <= TO;
    e.valid = i.valid;
    e.rw    = i.valid && i.rw && i.dest != 0;
    e.dest  = i.dest;
    e.data  = i.m2r ? (acked ? i.rdata : 32'h0) : i.alu;
    return e;
  endfunction

  task automatic step(input ins_t in, output logic took);
    exp_t e;
    @(negedge clk);
    ex_valid      = in.valid;
    ex_alu_out    = in.alu;
    ex_wdata      = in.wdata;
    ex_reg_dest   = in.dest;
    ex_mem_read   = in.rd;
    ex_mem_write  = in.wr;
    ex_reg_write  = in.rw;
    ex_mem_to_reg = in.m2r;
    if (dmem_req) begin
      acc++;
      req_cnt++;
      checks++;
      if (!exm_full || dmem_addr !== exm.alu || dmem_we !== exm.wr ||
          (exm.wr && dmem_wdata !== exm.wdata)) begin
        errors++;
        $display("FAIL dmem_bus: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                 dmem_addr, dmem_we, dmem_wdata, exm.alu, exm.wr, exm.wdata);
      end
    end
    dmem_ack   = dmem_req && exm_full && exm.lat != 0 && acc == exm.lat;
    dmem_rdata = dmem_ack ? exm.rdata : 32'hBAD0_BAD0;
    #1;
    took = !stall;
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
    if (took) begin
      if (exm_full) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: retirement with empty queue");
        end else begin
          e = sb.pop_front();
          if (e.rw) wr_cnt++;
          if (wb_valid !== e.valid || wb_reg_write !== e.rw ||
              (e.valid && wb_data !== e.data) ||
              (e.rw && wb_reg_dest !== e.dest)) begin
            errors++;
            $display("FAIL writeback: v=%b we=%b dest=%0d data=%h, required v=%b we=%b dest=%0d data=%h",
                     wb_valid, wb_reg_write, wb_reg_dest, wb_data,
                     e.valid, e.rw, e.dest, e.data);
          end
        end
      end
      exm      = in;
      exm_full = 1'b1;
      acc      = 0;
      sb.push_back(expect_of(in));
    end
  endtask

  task automatic issue(input ins_t in);
    logic took;
    int   n;
    n = 0;
    do begin
      step(in, took);
      n++;
    end while (!took && n < 20);
    if (!took) begin
      errors++;
      checks++;
      $display("FAIL issue_timeout: stall held %0d cycles, required release", n);
    end
  endtask

  task automatic clear_counts();
    req_cnt = 0;
    stall_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exm_full = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b0 ||
        wb_data !== 32'h0 || pre_data !== 32'h0 || mem_err !== 1'b0 ||
        pre_reg_write !== 1'b0 || wb_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset: stall=%b req=%b wbv=%b wbd=%h pre=%h err=%b, required all 0",
               stall, dmem_req, wb_valid, wb_data, pre_data, mem_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    clear_counts();
    issue(mk(1'b1, 32'h10, '0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0));
    checks++;
    if (pre_data !== 32'h10 || pre_reg_dest !== 5'd5 || pre_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL alu_pre: data=%h dest=%0d we=%b, required 10 5 1",
               pre_data, pre_reg_dest, pre_reg_write);
    end
    issue(bubble());
    checks++;
    if (wb_data !== 32'h10 || wb_reg_dest !== 5'd5 || wb_reg_write !== 1'b1 ||
        stall_cnt != 0) begin
      errors++;
      $display("FAIL alu_wb: data=%h dest=%0d we=%b stalls=%0d, required 10 5 1 0",
               wb_data, wb_reg_dest, wb_reg_write, stall_cnt);
    end
  endtask

  task automatic test_load_wait();
    clear_counts();
    issue(mk(1'b1, 32'h80, '0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF));
    issue(bubble());
    checks++;
    if (req_cnt != 3 || stall_cnt != 2) begin
      errors++;
      $display("FAIL load_timing: req=%0d stall=%0d, required 3 2", req_cnt, stall_cnt);
    end
    checks++;
    if (wb_data !== 32'hDEAD_BEEF || wr_cnt != 1) begin
      errors++;
      $display("FAIL load_data: data=%h writes=%0d, required deadbeef 1", wb_data, wr_cnt);
    end
  endtask

  task automatic test_store();
    clear_counts();
    issue(mk(1'b1, 32'h40, 32'h1234, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1, '0));
    issue(bubble());
    checks++;
    if (req_cnt != 1 || stall_cnt != 0 || wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL store: req=%0d stall=%0d we=%b v=%b, required 1 0 0 1",
               req_cnt, stall_cnt, wb_reg_write, wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    issue(mk(1'b1, 32'h100, '0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h1111_1111));
    issue(mk(1'b1, 32'h104, '0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h2222_2222));
    checks++;
    if (wb_data !== 32'h1111_1111 || wb_reg_dest !== 5'd8) begin
      errors++;
      $display("FAIL b2b_first: data=%h dest=%0d, required 11111111 8", wb_data, wb_reg_dest);
    end
    issue(bubble());
    checks++;
    if (wb_data !== 32'h2222_2222 || req_cnt != 2 || stall_cnt != 0) begin
      errors++;
      $display("FAIL b2b_second: data=%h req=%0d stall=%0d, required 22222222 2 0",
               wb_data, req_cnt, stall_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_counts();
    issue(mk(1'b1, 32'h200, '0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'hFFFF_FFFF));
    issue(bubble());
    checks++;
    if (req_cnt != TO || stall_cnt != TO - 1 || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: req=%0d stall=%0d err=%b, required %0d %0d 1",
               req_cnt, stall_cnt, mem_err, TO, TO - 1);
    end
    checks++;
    if (wb_data !== 32'h0 || wb_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL timeout_wb: data=%h we=%b, required 0 1", wb_data, wb_reg_write);
    end
    issue(bubble());
    checks++;
    if (mem_err !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b stall=%b, required 1 0", mem_err, stall);
    end
  endtask

  task automatic test_zero_dest();
    issue(mk(1'b1, 32'h55, '0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0));
    checks++;
    if (pre_reg_write !== 1'b0 || pre_data !== 32'h55) begin
      errors++;
      $display("FAIL zero_pre: we=%b data=%h, required 0 55", pre_reg_write, pre_data);
    end
    issue(bubble());
    checks++;
    if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_wb: we=%b v=%b, required 0 1", wb_reg_write, wb_valid);
    end
  endtask

  task automatic test_rst_mid();
    issue(mk(1'b1, 32'h300, '0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 0, '0));
    @(negedge clk);
    ex_valid = 1'b0;
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: req=%b stall=%b, required 1 1", dmem_req, stall);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 ||
        wb_data !== 32'h0 || pre_data !== 32'h0 || mem_err !== 1'b0 ||
        dmem_we !== 1'b0 || dmem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: req=%b stall=%b wbv=%b wbd=%h pre=%h err=%b, required all 0",
               dmem_req, stall, wb_valid, wb_data, pre_data, mem_err);
    end
    exm_full = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(bubble());
    issue(bubble());
    checks++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: wbv=%b req=%b, required 0 0", wb_valid, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_timeout();
    test_zero_dest();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
